// File: rtl/exp_unpacker_if.sv
// Handshake and BRAM port bundle between the fetcher/dispatcher BRAM and the
// exponent unpacker. The unpacker uses the slave view; the fetcher/BRAM side
// (or a testbench standing in for it) uses the master view.
interface exp_unpacker_if #(
    parameter int MAN_WIDTH             = 256,
    parameter int EXP_WIDTH             = 8,
    parameter int EXP_PACKED_DEPTH      = 16,
    parameter int BRAM_DEPTH            = 512,
    parameter int RD_ADDR_WIDTH         = $clog2(BRAM_DEPTH),
    parameter int EXP_PACKED_ADDR_WIDTH = $clog2(EXP_PACKED_DEPTH)
);
    logic                             i_start;
    logic                             i_target;
    logic [RD_ADDR_WIDTH:0]           i_num_exp;
    logic                             o_busy;
    logic                             o_done;
    logic [EXP_PACKED_ADDR_WIDTH-1:0] o_exp_packed_rd_addr;
    logic                             o_exp_packed_rd_target;
    logic [MAN_WIDTH-1:0]             i_exp_packed_rd_data;
    logic [RD_ADDR_WIDTH-1:0]         o_exp_left_wr_addr;
    logic                             o_exp_left_wr_en;
    logic [EXP_WIDTH-1:0]             o_exp_left_wr_data;
    logic [RD_ADDR_WIDTH-1:0]         o_exp_right_wr_addr;
    logic                             o_exp_right_wr_en;
    logic [EXP_WIDTH-1:0]             o_exp_right_wr_data;

    modport slave (
        input  i_start, i_target, i_num_exp, i_exp_packed_rd_data,
        output o_busy, o_done, o_exp_packed_rd_addr, o_exp_packed_rd_target,
        output o_exp_left_wr_addr, o_exp_left_wr_en, o_exp_left_wr_data,
        output o_exp_right_wr_addr, o_exp_right_wr_en, o_exp_right_wr_data
    );

    modport master (
        output i_start, i_target, i_num_exp, i_exp_packed_rd_data,
        input  o_busy, o_done, o_exp_packed_rd_addr, o_exp_packed_rd_target,
        input  o_exp_left_wr_addr, o_exp_left_wr_en, o_exp_left_wr_data,
        input  o_exp_right_wr_addr, o_exp_right_wr_en, o_exp_right_wr_data
    );
endinterface

// File: rtl/exp_unpacker.sv
// Exponent unpacker: reads packed exponent lines one at a time, then writes
// their bytes (least significant first) one per cycle into the left or right
// aligned exponent buffer. One idle cycle per line is spent loading the line.
module exp_unpacker #(
    parameter int MAN_WIDTH             = 256,
    parameter int EXP_WIDTH             = 8,
    parameter int EXP_PACKED_DEPTH      = 16,
    parameter int BRAM_DEPTH            = 512,
    parameter int RD_ADDR_WIDTH         = $clog2(BRAM_DEPTH),
    parameter int EXP_PACKED_ADDR_WIDTH = $clog2(EXP_PACKED_DEPTH)
) (
    input logic            i_clk,
    input logic            i_reset_n,
    exp_unpacker_if.slave  bus
);
    localparam int EXP_PER_LINE = MAN_WIDTH / EXP_WIDTH;
    localparam int K_W          = $clog2(EXP_PER_LINE);
    localparam int CNT_W        = RD_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic                   target_q, target_d;
    logic [MAN_WIDTH-1:0]   line_q, line_d;

    logic                             accept;
    logic [CNT_W-1:0]               num_clamped;
    logic [K_W-1:0]                   byte_idx;
    logic [EXP_PACKED_ADDR_WIDTH-1:0] line_idx;
    logic                             last_wr;
    logic                             line_end;

    logic                             busy;
    logic                             done;
    logic [EXP_PACKED_ADDR_WIDTH-1:0] rd_addr;
    logic                             rd_target;
    logic [RD_ADDR_WIDTH-1:0]         left_addr, right_addr;
    logic                             left_en, right_en;
    logic [EXP_WIDTH-1:0]             left_data, right_data;

    // Requests beyond the buffer depth are clamped so addresses never wrap.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] num);
        if (num > CNT_W'(BRAM_DEPTH))
            return CNT_W'(BRAM_DEPTH);
        return num;
    endfunction

    // The write counter doubles as the aligned address: upper bits pick the
    // packed line, lower bits pick the byte inside it.
    assign byte_idx    = cnt_q[K_W-1:0];
    assign line_idx    = cnt_q[K_W +: EXP_PACKED_ADDR_WIDTH];
    assign last_wr     = (cnt_q + CNT_W'(1)) == n_q;
    assign line_end    = &byte_idx;
    assign accept      = bus.i_start && (state_q == IDLE || state_q == DONE);
    assign num_clamped = clamp_count(bus.i_num_exp);

    // Control state register; reset aborts any run in progress.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            target_q <= target_d;
        end
    end

    // Line buffer holds the packed line being emitted; data only, no reset.
    always_ff @(posedge i_clk) begin
        line_q <= line_d;
    end

    // Next-state logic: a start is accepted in IDLE and in the DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept)
                    state_d = (num_clamped == '0) ? DONE : LOAD;
            end
            LOAD:    state_d = EMIT;
            EMIT: begin
                if (last_wr)
                    state_d = DONE;
                else if (line_end)
                    state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, count, target and line register updates.
    always_comb begin
        cnt_d    = cnt_q;
        n_d      = n_q;
        target_d = target_q;
        line_d   = line_q;
        case (state_q)
            IDLE, DONE: begin
                cnt_d = '0;
                if (state_q == DONE)
                    n_d = '0;
                if (accept) begin
                    n_d      = num_clamped;
                    target_d = bus.i_target;
                end
            end
            LOAD:    line_d = bus.i_exp_packed_rd_data;
            EMIT:    cnt_d  = cnt_q + CNT_W'(1);
            default: ;
        endcase
    end

    // Output decode from registered state only; the unused side stays at zero.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        rd_addr    = '0;
        rd_target  = 1'b0;
        left_addr  = '0;
        left_en    = 1'b0;
        left_data  = '0;
        right_addr = '0;
        right_en   = 1'b0;
        right_data = '0;
        case (state_q)
            LOAD: begin
                busy      = 1'b1;
                rd_addr   = line_idx;
                rd_target = target_q;
            end
            EMIT: begin
                busy = 1'b1;
                if (target_q) begin
                    right_en   = 1'b1;
                    right_addr = cnt_q[RD_ADDR_WIDTH-1:0];
                    right_data = line_q[EXP_WIDTH*int'(byte_idx) +: EXP_WIDTH];
                end else begin
                    left_en    = 1'b1;
                    left_addr  = cnt_q[RD_ADDR_WIDTH-1:0];
                    left_data  = line_q[EXP_WIDTH*int'(byte_idx) +: EXP_WIDTH];
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_busy                 = busy;
    assign bus.o_done                 = done;
    assign bus.o_exp_packed_rd_addr   = rd_addr;
    assign bus.o_exp_packed_rd_target = rd_target;
    assign bus.o_exp_left_wr_addr     = left_addr;
    assign bus.o_exp_left_wr_en       = left_en;
    assign bus.o_exp_left_wr_data     = left_data;
    assign bus.o_exp_right_wr_addr    = right_addr;
    assign bus.o_exp_right_wr_en      = right_en;
    assign bus.o_exp_right_wr_data    = right_data;
endmodule
